// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ byte sources
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_busy,
  output logic              send_en,
  output logic [7:0]        send_data,
  output logic [IDW-1:0]    grant_id,
  output logic              tx_active,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  // Start with the pointer on the last requester so requester 0 wins first.
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [7:0]      hold_q [NREQ];
  logic [7:0]      hold_d [NREQ];
  logic            send_en_q, send_en_d;
  logic [7:0]      send_data_q, send_data_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            terr_q, terr_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  probe;

  assign req_ready   = ~pend_q;
  assign send_en     = send_en_q;
  assign send_data   = send_data_q;
  assign grant_id    = grant_q;
  assign tx_active   = (state_q != ST_IDLE);
  assign timeout_err = terr_q;

  // Round-robin pick: first pending slot after the last one served, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_q;
    probe     = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      probe = IDW'((int'(last_q) + k) % NREQ);
      if (!gnt_found && pend_q[probe]) begin
        gnt_found = 1'b1;
        gnt_idx   = probe;
      end
    end
  end

  // Slot acceptance, grant issue and TX handshake state machine.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    hold_d      = hold_q;
    send_en_d   = 1'b0;
    send_data_d = send_data_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    terr_d      = 1'b0;

    // A slot only accepts while empty, so it never collides with its own grant.
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        hold_d[i] = req_data[8*i +: 8];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_found && !tx_busy) begin
          send_en_d        = 1'b1;
          send_data_d      = hold_q[gnt_idx];
          grant_d          = gnt_idx;
          last_d           = gnt_idx;
          pend_d[gnt_idx]  = 1'b0;
          cnt_d            = '0;
          state_d          = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never started: drop the byte, its slot is already free.
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous discard of everything pending.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      for (int i = 0; i < NREQ; i++) begin
        hold_q[i] <= 8'h00;
      end
      send_en_q   <= 1'b0;
      send_data_q <= 8'h00;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      send_en_q   <= send_en_d;
      send_data_q <= send_data_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_busy;
  logic        send_en;
  logic [7:0]  send_data;
  logic [1:0]  grant_id;
  logic        tx_active;
  logic        timeout_err;

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_busy    (tx_busy),
    .send_en    (send_en),
    .send_data  (send_data),
    .grant_id   (grant_id),
    .tx_active  (tx_active),
    .timeout_err(timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // TX model: busy rises the cycle after send_en and stays high for 10 cycles.
  bit model_on  = 1'b0;
  bit start_pend = 1'b0;
  int busy_left = 0;
  always @(negedge sys_clk) if (model_on && send_en) start_pend = 1'b1;
  always @(posedge sys_clk) begin
    #1;
    if (model_on) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (start_pend) begin
        start_pend = 1'b0;
        tx_busy    = 1'b1;
        busy_left  = 10;
      end
    end
  end

  // Send and timeout monitor with cycle stamps.
  int cyc = 0;
  logic prev_se = 1'b0;
  int   sq_gid[$];
  int   sq_data[$];
  int   sq_cyc[$];
  int   te_cyc[$];
  always @(posedge sys_clk) cyc++;
  always @(negedge sys_clk) begin
    if (send_en) begin
      check("no_back_to_back_send_en", {31'b0, prev_se}, 32'd0);
      sq_gid.push_back(int'(grant_id));
      sq_data.push_back(int'(send_data));
      sq_cyc.push_back(cyc);
    end
    if (timeout_err) te_cyc.push_back(cyc);
    prev_se = send_en;
  end

  task automatic do_reset(input logic busy_hold);
    model_on   = 1'b0;
    start_pend = 1'b0;
    busy_left  = 0;
    tx_busy    = busy_hold;
    req_valid  = 4'b0000;
    sys_rst_n  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    sq_gid.delete();
    sq_data.delete();
    sq_cyc.delete();
    te_cyc.delete();
  endtask

  task automatic wait_sends(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (sq_gid.size() < n && b < budget) begin
      @(posedge sys_clk);
      #1;
      b++;
    end
    if (sq_gid.size() < n) check({name, "_wait_expired"}, sq_gid.size(), n);
  endtask

  typedef struct {
    logic [3:0] v;
    logic       busy;
    logic       se;
    logic [7:0] sd;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       act;
    logic       te;
  } vec_t;

  vec_t tbl[13];

  initial begin : watchdog
    #400000;
    $display("FAIL global_watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b;
    sys_rst_n = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_busy   = 1'b0;

    // Each row: inputs for the coming edge, outputs expected before that edge.
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1110, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b0, 1'b1, 8'hA0, 2'd0, 4'b1111, 1'b1, 1'b0};
    tbl[3]  = '{4'b0110, 1'b1, 1'b0, 8'hA0, 2'd0, 4'b1111, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 8'hA0, 2'd0, 4'b1001, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 8'hA0, 2'd0, 4'b1001, 1'b1, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 8'hA0, 2'd0, 4'b1001, 1'b0, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 8'hA1, 2'd1, 4'b1011, 1'b1, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 8'hA1, 2'd1, 4'b1011, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 8'hA1, 2'd1, 4'b1011, 1'b1, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 8'hA1, 2'd1, 4'b1011, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 8'hA1, 2'd1, 4'b1011, 1'b0, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 8'hA2, 2'd2, 4'b1111, 1'b1, 1'b0};

    // Table: directly driven tx_busy, cycle-by-cycle handshake and grant order.
    do_reset(1'b0);
    req_data = 32'hA3A2A1A0;
    for (int k = 0; k < 13; k++) begin
      req_valid = tbl[k].v;
      tx_busy   = tbl[k].busy;
      @(negedge sys_clk);
      check($sformatf("row%0d_send_en", k),     {31'b0, send_en},     {31'b0, tbl[k].se});
      check($sformatf("row%0d_send_data", k),   {24'b0, send_data},   {24'b0, tbl[k].sd});
      check($sformatf("row%0d_grant_id", k),    {30'b0, grant_id},    {30'b0, tbl[k].gid});
      check($sformatf("row%0d_req_ready", k),   {28'b0, req_ready},   {28'b0, tbl[k].rdy});
      check($sformatf("row%0d_tx_active", k),   {31'b0, tx_active},   {31'b0, tbl[k].act});
      check($sformatf("row%0d_timeout_err", k), {31'b0, timeout_err}, {31'b0, tbl[k].te});
      @(posedge sys_clk);
      #1;
    end

    // Single byte with the TX model.
    do_reset(1'b0);
    model_on  = 1'b1;
    req_data  = 32'h00000041;
    req_valid = 4'b0001;
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0000;
    @(negedge sys_clk);
    check("single_ready0_after_accept", {31'b0, req_ready[0]}, 32'd0);
    check("single_no_send_yet", {31'b0, send_en}, 32'd0);
    @(negedge sys_clk);
    check("single_send_en", {31'b0, send_en}, 32'd1);
    check("single_send_data", {24'b0, send_data}, 32'h41);
    check("single_grant_id", {30'b0, grant_id}, 32'd0);
    check("single_ready0_after_grant", {31'b0, req_ready[0]}, 32'd1);
    repeat (30) @(posedge sys_clk);
    #1;
    check("single_send_count", sq_gid.size(), 32'd1);

    // Fairness: all requesters always valid.
    do_reset(1'b0);
    model_on  = 1'b1;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    wait_sends(8, 300, "fair");
    req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (i < sq_gid.size()) begin
        check($sformatf("fair_gid%0d", i), sq_gid[i], i % 4);
        check($sformatf("fair_data%0d", i), sq_data[i], 32'h10 + (i % 4));
      end
    end

    // Starvation: requester 2 streams, requester 1 posts once.
    do_reset(1'b0);
    model_on  = 1'b1;
    req_data  = 32'h00221100;
    req_valid = 4'b0100;
    wait_sends(1, 20, "starve_first");
    req_valid = 4'b0110;
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0100;
    wait_sends(3, 100, "starve");
    req_valid = 4'b0000;
    if (sq_gid.size() >= 3) begin
      check("starve_first_gid", sq_gid[0], 32'd2);
      check("starve_next_gid", sq_gid[1], 32'd1);
      check("starve_next_data", sq_data[1], 32'h11);
      check("starve_then_gid", sq_gid[2], 32'd2);
    end

    // Busy held across reset release with slot 3 pending.
    do_reset(1'b1);
    req_data  = 32'h77000000;
    req_valid = 4'b1000;
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0000;
    repeat (20) @(posedge sys_clk);
    #1;
    check("busy_hold_no_send", sq_gid.size(), 32'd0);
    tx_busy = 1'b0;
    wait_sends(1, 10, "busy_hold");
    if (sq_gid.size() >= 1) begin
      check("busy_hold_gid", sq_gid[0], 32'd3);
      check("busy_hold_data", sq_data[0], 32'h77);
    end

    // Timeout: transmitter never goes busy.
    do_reset(1'b0);
    req_data  = 32'h00006655;
    req_valid = 4'b0011;
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0000;
    wait_sends(2, 60, "timeout");
    repeat (3) @(posedge sys_clk);
    #1;
    check("timeout_err_count", te_cyc.size(), 32'd1);
    if (sq_gid.size() >= 2 && te_cyc.size() >= 1) begin
      check("timeout_after_send", te_cyc[0] - sq_cyc[0], 32'd16);
      check("timeout_next_grant", sq_cyc[1] - te_cyc[0], 32'd1);
      check("timeout_next_gid", sq_gid[1], 32'd1);
      check("timeout_next_data", sq_data[1], 32'h66);
    end

    // Reset in WAIT_DONE with three slots still pending.
    do_reset(1'b0);
    model_on  = 1'b1;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0000;
    wait_sends(1, 10, "rst_mid");
    b = 0;
    while (!tx_busy && b < 20) begin
      @(posedge sys_clk);
      #1;
      b++;
    end
    @(posedge sys_clk);
    #1;
    check("rst_mid_active_before", {31'b0, tx_active}, 32'd1);
    check("rst_mid_ready_before", {28'b0, req_ready}, 32'b0001);
    #2;
    sys_rst_n  = 1'b0;
    model_on   = 1'b0;
    start_pend = 1'b0;
    busy_left  = 0;
    tx_busy    = 1'b0;
    #1;
    check("rst_mid_ready", {28'b0, req_ready}, 32'b1111);
    check("rst_mid_send_en", {31'b0, send_en}, 32'd0);
    check("rst_mid_send_data", {24'b0, send_data}, 32'h00);
    check("rst_mid_grant_id", {30'b0, grant_id}, 32'd0);
    check("rst_mid_tx_active", {31'b0, tx_active}, 32'd0);
    check("rst_mid_timeout_err", {31'b0, timeout_err}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    sq_gid.delete();
    sq_data.delete();
    sq_cyc.delete();
    model_on = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1;
    check("rst_mid_no_send_after", sq_gid.size(), 32'd0);
    req_valid = 4'b0010;
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0000;
    wait_sends(1, 10, "rst_mid_new");
    if (sq_gid.size() >= 1) begin
      check("rst_mid_new_gid", sq_gid[0], 32'd1);
      check("rst_mid_new_data", sq_data[0], 32'h11);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (send_en/send_data/tx_busy interface) among NREQ byte sources, e.g. the echo path and the LC-3 console output. Each requester gets a one-byte holding slot with a valid/ready handshake. A round-robin scheduler drains the slots into the transmitter, one byte per TX frame, and a timeout guards against a transmitter that never goes busy.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): width of grant_id.
- TIMEOUT, 16: cycles allowed in WAIT_BUSY for tx_busy to rise, >=2.

- sys_clk  in  1  clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i offers a byte.
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- req_ready  out  NREQ  slot i empty; equals ~pend[i] (combinational from register).
- tx_busy  in  1  UART TX frame in progress.
- send_en  out  1  one-cycle start pulse to UART TX.
- send_data  out  8  byte to transmit, held stable from send_en until the next grant.
- grant_id  out  IDW  index of the requester currently or last served.
- tx_active  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse: tx_busy failed to rise within TIMEOUT cycles.

## Operation
- Per slot i: pend[i] and hold[i][7:0]. Accept on req_valid[i] & req_ready[i] at a clock edge: hold[i]<=data, pend[i]<=1.
- Round-robin pointer last[IDW]. The search starts at (last+1) mod NREQ and picks the first pend bit set.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if |pend and !tx_busy, then at the next edge:
  - send_en<=1, send_data<=hold[g], grant_id<=g, last<=g, pend[g]<=0, cnt<=0.
  - state<=WAIT_BUSY.
- IDLE with tx_busy=1: wait, no grant.
- WAIT_BUSY: send_en<=0 every cycle. cnt increments each cycle.
  - If tx_busy=1, go to WAIT_DONE.
  - Else if cnt==TIMEOUT-1: timeout_err<=1 for one cycle, go to IDLE. The byte is dropped; its slot was already freed.
- WAIT_DONE: on tx_busy=0, go to IDLE.
- Slot i may be refilled from the cycle after its grant, so a requester can stream back-to-back bytes.
- A slot being granted cannot accept in the same edge, because req_ready[i] is 0 while pend[i]=1.
- Acceptances into other slots proceed in any state.
- Reset values:
  - state=IDLE, pend=0, so req_ready is all ones.
  - hold=0, send_en=0, send_data=8'h00, grant_id=0.
  - last=NREQ-1, so requester 0 has priority first.
  - tx_active=0, timeout_err=0, cnt=0.
- Reset mid-operation: all state and pending bytes are discarded immediately (asynchronous). No send_en is issued until after reset deasserts.

## Timing
- Accept at edge E0, pend visible after E0. If IDLE and !tx_busy, the grant happens at E1 and send_en is high for exactly the cycle after E1.
- Minimum accept-to-send_en latency: 1 cycle after the accepting edge.
- send_en is never high for 2 consecutive cycles. It never asserts while state != IDLE at the prior edge or while tx_busy=1 is sampled.
- Frame-to-frame: after tx_busy falls (sampled at edge F), state is IDLE after F. The next grant is at F+1, so the next send_en is 2 edges after the fall.
- Timeout path: send_en cycle, then TIMEOUT cycles in WAIT_BUSY. timeout_err pulses coincident with entry to IDLE. The next grant is possible one edge later.
- Simultaneous requests in IDLE: exactly one grant per frame, in round-robin order.

## Test plan
- Single byte: req_valid[0]=1, data 8'h41, with the TX model raising busy 1 cycle after send_en for 10 cycles -> one send_en pulse, send_data=8'h41, grant_id=0, req_ready[0] back to 1 the cycle after the grant.
- Fairness: all 4 requesters hold valid continuously with bytes 8'h10+i -> send order 0,1,2,3,0,1,... and send_data is 10,11,12,13,10,...
- Starvation check: requester 2 streams continuously; requester 1 posts once -> requester 1 is served on the frame immediately after the current one.
- tx_busy held high at reset release for 20 cycles with pend[3]=1 -> no send_en until busy is low, then send_data=hold[3].
- Timeout: TX model never asserts busy (TIMEOUT=16) -> timeout_err pulses exactly once, 16 cycles after send_en, and the next pending byte is granted 1 edge later.
- Reset mid-frame: assert sys_rst_n=0 in WAIT_DONE with 3 slots pending -> all outputs at reset values immediately, req_ready=4'b1111, and no send_en after release until a new request arrives.
